fp32_divider: RTL and testbench

//   Sequential IEEE-754 single-precision divider: result = a / b.

---
 rtl/fp_div_pkg.sv | 34 +++
 rtl/fp32_divider_if.sv | 25 ++
 rtl/mant_restoring_div.sv | 47 ++++
 rtl/fp32_divider.sv | 158 +++++++++++++++
 tb/tb_fp32_divider.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, state encoding and operand field helpers for the
// sequential single-precision divider.
package fp_div_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int ITER  = MAN_W + 2;

    localparam logic [W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } flags_t;

    function automatic logic sign_of(input logic [W-1:0] x);
        return x[W-1];
    endfunction

    function automatic logic [EXP_W-1:0] exp_of(input logic [W-1:0] x);
        return x[W-2:MAN_W];
    endfunction

    function automatic logic [MAN_W-1:0] frac_of(input logic [W-1:0] x);
        return x[MAN_W-1:0];
    endfunction

endpackage

// File: rtl/fp32_divider_if.sv
// Start/done handshake, operands and registered result/flags of the divider.
interface fp32_divider_if import fp_div_pkg::*; ();

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;
    logic         invalid;
    logic         overflow;
    logic         underflow;

    modport master (
        output start, a, b,
        input  busy, done, result, div_by_zero, invalid, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, div_by_zero, invalid, overflow, underflow
    );

endinterface

// File: rtl/mant_restoring_div.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
module mant_restoring_div import fp_div_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [MAN_W:0]   ma,
    input  logic [MAN_W:0]   mb,
    output logic [MAN_W+1:0] q,
    output logic             last
);

    localparam int CNT_W = $clog2(ITER);

    logic [MAN_W+1:0] rem;
    logic [MAN_W:0]   div_r;
    logic [CNT_W-1:0] cnt;
    logic             ge;
    logic [MAN_W+1:0] rem_next;

    // The remainder stays below twice the divisor, so the shifted value fits.
    always_comb begin
        ge       = rem >= {1'b0, div_r};
        rem_next = (ge ? rem - {1'b0, div_r} : rem) << 1;
    end

    assign last = (cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            div_r <= '0;
            q     <= '0;
            cnt   <= '0;
        end else if (load) begin
            rem   <= {1'b0, ma};
            div_r <= mb;
            q     <= '0;
            cnt   <= '0;
        end else if (step) begin
            rem   <= rem_next;
            q     <= {q[MAN_W:0], ge};
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider, flush-to-zero, truncating.
module fp32_divider import fp_div_pkg::*; (
    input  logic          clk,
    input  logic          rst_n,
    fp32_divider_if.slave io
);

    localparam logic [EXP_W-1:0]        EXP_MAX = '1;
    localparam logic signed [EXP_W+1:0] BIAS_E  = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] OVF_E   = (EXP_W+2)'(2**EXP_W - 1);
    localparam logic signed [EXP_W+1:0] ONE_E   = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] ZERO_E  = '0;

    state_t                  state;
    logic                    sign_r;
    logic signed [EXP_W+1:0] exp_r;
    logic [W-1:0]            pend_result;
    flags_t                  pend_flags;

    logic             sa, sb, sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign sa   = sign_of(io.a);
    assign sb   = sign_of(io.b);
    assign ea   = exp_of(io.a);
    assign eb   = exp_of(io.b);
    assign fa   = frac_of(io.a);
    assign fb   = frac_of(io.b);
    assign sign = sa ^ sb;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);

    logic         is_special;
    logic [W-1:0] spec_result;
    flags_t       spec_flags;

    // Earlier branches win: NaN-producing cases beat divide-by-zero beat inf/zero.
    always_comb begin
        is_special  = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result        = QNAN;
            spec_flags.invalid = 1'b1;
        end else if (b_zero) begin
            spec_result            = {sign, EXP_MAX, {MAN_W{1'b0}}};
            spec_flags.div_by_zero = 1'b1;
        end else if (a_inf) begin
            spec_result = {sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
            spec_result = {sign, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    logic signed [EXP_W+1:0] e_calc;
    assign e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;

    logic             load, step, last;
    logic [MAN_W+1:0] q;

    assign load = (state == IDLE) && io.start && !is_special;
    assign step = (state == DIVIDE);

    mant_restoring_div u_mant (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .ma    ({1'b1, fa}),
        .mb    ({1'b1, fb}),
        .q     (q),
        .last  (last)
    );

    logic [MAN_W-1:0]        norm_frac;
    logic signed [EXP_W+1:0] norm_exp;
    logic [W-1:0]            norm_result;
    flags_t                  norm_flags;

    // A quotient below 1.0 lies in [0.5,1), so one left shift normalises it.
    always_comb begin
        norm_frac   = q[MAN_W+1] ? q[MAN_W:1] : q[MAN_W-1:0];
        norm_exp    = q[MAN_W+1] ? exp_r : exp_r - ONE_E;
        norm_flags  = '0;
        norm_result = {sign_r, norm_exp[EXP_W-1:0], norm_frac};
        if (norm_exp >= OVF_E) begin
            norm_flags.overflow = 1'b1;
            norm_result         = {sign_r, EXP_MAX, {MAN_W{1'b0}}};
        end else if (norm_exp <= ZERO_E) begin
            norm_flags.underflow = 1'b1;
            norm_result          = {sign_r, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sign_r         <= 1'b0;
            exp_r          <= '0;
            pend_result    <= '0;
            pend_flags     <= '0;
            io.busy        <= 1'b0;
            io.done        <= 1'b0;
            io.result      <= '0;
            io.invalid     <= 1'b0;
            io.div_by_zero <= 1'b0;
            io.overflow    <= 1'b0;
            io.underflow   <= 1'b0;
        end else begin
            io.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        io.busy <= 1'b1;
                        sign_r  <= sign;
                        exp_r   <= e_calc;
                        if (is_special) begin
                            pend_result <= spec_result;
                            pend_flags  <= spec_flags;
                            state       <= DONE;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (last) state <= NORM;
                end
                NORM: begin
                    pend_result <= norm_result;
                    pend_flags  <= norm_flags;
                    state       <= DONE;
                end
                DONE: begin
                    io.result      <= pend_result;
                    io.invalid     <= pend_flags.invalid;
                    io.div_by_zero <= pend_flags.div_by_zero;
                    io.overflow    <= pend_flags.overflow;
                    io.underflow   <= pend_flags.underflow;
                    io.done        <= 1'b1;
                    io.busy        <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Randomised and directed checks of fp32_divider against an arithmetic model.
module tb_fp32_divider;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  f;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fp32_divider_if io ();

    fp32_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    int          total    = 0;
    int          bad      = 0;
    int          done_cnt = 0;
    exp_t        exp_q[$];
    logic [31:0] held_r   = '0;
    logic [3:0]  held_f   = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Flags are ordered {invalid, div_by_zero, overflow, underflow}.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output logic [3:0] f, output bit spec);
        logic        s;
        int          ea, eb, e;
        longint      ma, mb, q;
        logic [22:0] fr;
        bit          za, zb, ia, ib, na, nb;
        s  = av[31] ^ bv[31];
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (av[22:0] == 0);
        ib = (eb == 255) && (bv[22:0] == 0);
        na = (ea == 255) && (av[22:0] != 0);
        nb = (eb == 255) && (bv[22:0] != 0);
        spec = 1;
        f    = 4'b0000;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (zb) begin
            r = {s, 8'hFF, 23'h0};
            f = 4'b0100;
        end else if (ia) begin
            r = {s, 8'hFF, 23'h0};
        end else if (za || ib) begin
            r = {s, 31'h0};
        end else begin
            spec = 0;
            ma = longint'({1'b1, av[22:0]});
            mb = longint'({1'b1, bv[22:0]});
            q  = (ma << 24) / mb;
            e  = ea - eb + 127;
            if (q >= (longint'(1) << 24)) begin
                fr = 23'(q >> 1);
            end else begin
                fr = 23'(q);
                e  = e - 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 4'b0010;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0001;
            end else begin
                r = {s, 8'(e), fr};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        int          c;
        x = $urandom;
        c = int'($urandom_range(0, 9));
        case (c)
            0:       x[30:23] = 8'h00;
            1:       begin x[30:23] = 8'hFF; x[22:0] = '0; end
            2:       begin x[30:23] = 8'hFF; x[0] = 1'b1; end
            default: x[30:23] = 8'($urandom_range(1, 254));
        endcase
        return x;
    endfunction

    // Every sampled cycle: a done pulse must match the oldest expectation,
    // otherwise the registered result and flags must hold their last value.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                held_r = '0;
                held_f = '0;
            end else if (io.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_done", 32'(io.done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result", io.result, e.r);
                    checkOutput("flags", 32'({io.invalid, io.div_by_zero, io.overflow, io.underflow}), 32'(e.f));
                    held_r = e.r;
                    held_f = e.f;
                end
            end else begin
                checkOutput("hold_result", io.result, held_r);
                checkOutput("hold_flags", 32'({io.invalid, io.div_by_zero, io.overflow, io.underflow}), 32'(held_f));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input int inject_at, input int abort_at);
        logic [31:0] r;
        logic [3:0]  f;
        bit          spec;
        int          k, exp_lat, busy_cyc;
        bit          got, aborted;
        model(av, bv, r, f, spec);
        exp_lat = spec ? 1 : 27;
        @(negedge clk);
        io.a     = av;
        io.b     = bv;
        io.start = 1'b1;
        exp_q.push_back('{r: r, f: f});
        @(posedge clk);
        #1;
        io.start = 1'b0;
        checkOutput("busy_on_accept", 32'(io.busy), 32'd1);
        k        = 0;
        busy_cyc = io.busy ? 1 : 0;
        got      = 0;
        aborted  = 0;
        while (!got && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (inject_at > 0 && k == inject_at - 1) begin
                io.a     = 32'h3F800000;
                io.b     = 32'h40400000;
                io.start = 1'b1;
            end else if (inject_at > 0 && k == inject_at) begin
                io.start = 1'b0;
            end
            if (io.done) got = 1;
            else if (io.busy) busy_cyc++;
            if (abort_at > 0 && k == abort_at) begin
                #3;
                rst_n = 1'b0;
                #1;
                checkOutput("abort_busy", 32'(io.busy), 32'd0);
                checkOutput("abort_result", io.result, 32'd0);
                checkOutput("abort_done", 32'(io.done), 32'd0);
                void'(exp_q.pop_back());
                @(posedge clk);
                @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            checkOutput("latency", 32'(k), 32'(exp_lat));
            checkOutput("busy_cycles", 32'(busy_cyc), 32'(exp_lat));
            checkOutput("busy_at_done", 32'(io.busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] mr;
        logic [3:0]  mf;
        bit          ms;
        int          d0;
        io.start = 1'b0;
        io.a     = '0;
        io.b     = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(io.busy), 32'd0);
        checkOutput("reset_done", 32'(io.done), 32'd0);
        checkOutput("reset_result", io.result, 32'd0);
        checkOutput("reset_flags", 32'({io.invalid, io.div_by_zero, io.overflow, io.underflow}), 32'd0);
        rst_n = 1'b1;

        model(32'h40C00000, 32'h40000000, mr, mf, ms);
        checkOutput("model_6div2", mr, 32'h40400000);
        model(32'h3F800000, 32'h40400000, mr, mf, ms);
        checkOutput("model_1div3", mr, 32'h3EAAAAAA);
        model(32'h7F000000, 32'h3E800000, mr, mf, ms);
        checkOutput("model_ovf", {mr[31:4], mf}, {28'h7F80000, 4'b0010});
        model(32'h00800000, 32'h4B000000, mr, mf, ms);
        checkOutput("model_udf", {mr[31:4], mf}, {28'h0000000, 4'b0001});

        applyStimulus(32'h40C00000, 32'h40000000, 0, 0);
        checkOutput("lit_6div2", io.result, 32'h40400000);
        applyStimulus(32'h3F800000, 32'h40400000, 0, 0);
        checkOutput("lit_1div3", io.result, 32'h3EAAAAAA);
        applyStimulus(32'hBF800000, 32'h00000000, 0, 0);
        checkOutput("lit_div0", io.result, 32'hFF800000);
        checkOutput("lit_div0_flag", 32'(io.div_by_zero), 32'd1);
        applyStimulus(32'h00000000, 32'h00000000, 0, 0);
        checkOutput("lit_0div0", io.result, 32'h7FC00000);
        checkOutput("lit_0div0_flag", 32'(io.invalid), 32'd1);
        applyStimulus(32'h7F000000, 32'h3E800000, 0, 0);
        checkOutput("lit_ovf", io.result, 32'h7F800000);
        checkOutput("lit_ovf_flag", 32'(io.overflow), 32'd1);
        applyStimulus(32'h00800000, 32'h4B000000, 0, 0);
        checkOutput("lit_udf", io.result, 32'h00000000);
        checkOutput("lit_udf_flag", 32'(io.underflow), 32'd1);

        d0 = done_cnt;
        applyStimulus(32'h40C00000, 32'h40000000, 5, 0);
        checkOutput("lit_busy_start", io.result, 32'h40400000);
        repeat (30) @(posedge clk);
        checkOutput("single_done", 32'(done_cnt - d0), 32'd1);

        applyStimulus(32'h3F800000, 32'h40400000, 0, 10);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        applyStimulus(32'h40C00000, 32'h40000000, 0, 0);
        checkOutput("lit_after_abort", io.result, 32'h40400000);

        repeat (40) applyStimulus(rand_op(), rand_op(), 0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
